// File: rtl/pc_jump_sequencer.sv
// Loads the PC from a two-byte pointer in data memory and shares the single read port with fetch.
// Jump commits MEM_LAT+3 cycles after acceptance; fetch gets the port only in IDLE and is not queued.
module pc_jump_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              pc_load,
    output logic              pc_write,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        ISSUE_HI,
        WAIT,
        COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [MEM_LAT-1:0]  issue_q, issue_d;
    logic [MEM_LAT-1:0]  hi_q, hi_d;
    logic                issue_now;
    logic                hi_now;
    logic [DATA_W-1:0]   ptr_lo_unused;

    // Tags travel alongside the reads so pc_load lines up with returning data for any MEM_LAT.
    assign issue_now = (state_q == ISSUE_LO) || (state_q == ISSUE_HI);
    assign hi_now    = (state_q == ISSUE_HI);
    assign issue_d   = MEM_LAT'({issue_q, issue_now});
    assign hi_d      = MEM_LAT'({hi_q, hi_now});

    assign pc_load       = issue_q[MEM_LAT-1];
    assign busy          = (state_q != IDLE);
    assign done          = pc_write;
    assign ptr_lo_unused = ptr_q[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            issue_q <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            issue_q <= issue_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        fetch_grant = 1'b0;
        mem_addr    = fetch_addr;
        mem_rd      = 1'b0;
        pc_write    = 1'b0;
        case (state_q)
            IDLE: begin
                if (jump_req) begin
                    state_d = ISSUE_LO;
                    ptr_d   = jump_addr;
                end else begin
                    fetch_grant = fetch_req;
                    mem_rd      = fetch_req;
                end
            end
            ISSUE_LO: begin
                mem_addr = ptr_q;
                mem_rd   = 1'b1;
                state_d  = ISSUE_HI;
            end
            ISSUE_HI: begin
                mem_addr = ptr_q + ADDR_W'(1);
                mem_rd   = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // High byte is on the bus this cycle; the load unit captures it now.
                if (hi_q[MEM_LAT-1]) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                pc_write = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_jump_sequencer.sv
// Runs MEM_LAT=1 and MEM_LAT=3 instances side by side on shared stimulus, each against its own model,
// memory and PC load unit; committed PCs are scoreboarded against pointer contents read at acceptance.
module tb_pc_jump_sequencer;

    logic              clk;
    logic              reset;
    logic              jump_req;
    logic [15:0]       jump_addr;
    logic              fetch_req;
    logic [15:0]       fetch_addr;
    logic [1:0]        fetch_grant_w;
    logic [1:0]        mem_rd_w;
    logic [1:0]        pc_load_w;
    logic [1:0]        pc_write_w;
    logic [1:0]        busy_w;
    logic [1:0]        done_w;
    logic [1:0][15:0]  mem_addr_w;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pc_jump_sequencer #(
            .ADDR_W (16),
            .DATA_W (8),
            .MEM_LAT((g == 0) ? 1 : 3)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .jump_req   (jump_req),
            .jump_addr  (jump_addr),
            .fetch_req  (fetch_req),
            .fetch_addr (fetch_addr),
            .fetch_grant(fetch_grant_w[g]),
            .mem_addr   (mem_addr_w[g]),
            .mem_rd     (mem_rd_w[g]),
            .pc_load    (pc_load_w[g]),
            .pc_write   (pc_write_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    logic [7:0]  mem [0:65535];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    // Reference model: m_cnt = 0 when idle, else the 1-based cycle within the sequence
    int          m_cnt [2] = '{0, 0};
    logic [15:0] m_ptr [2];
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    logic [15:0] pr_hi_a;
    logic [15:0] pr_pc;

    // Stimulus-owned directives read by the monitor
    logic        const_vld;
    logic [15:0] const_pc;
    logic        final_chk;

    // Monitor-owned state
    int          rd_idx [2] = '{0, 0};
    logic        rd_vld [2][8];
    logic [7:0]  rd_dat [2][8];
    logic        lo_seen [2];
    logic [7:0]  lo_b [2];
    logic [7:0]  hi_b [2];
    logic        final_done = 1'b0;
    int          mon_lat, mon_k, mon_slot;
    logic        mon_idle, mon_grant, mon_have;
    logic [7:0]  mon_rdata;
    logic [15:0] mon_got, mon_exp, mon_hi_a;

    function automatic void chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s L=%0d cyc=%0d got=%0h exp=%0h", nm, lat_of(i), cyc, got, exp);
        end
    endfunction

    // Predictor: advances the model at each edge and pushes the PC a jump must commit
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] == 0) begin
                if (jump_req) begin
                    m_cnt[i] = 1;
                    m_ptr[i] = jump_addr;
                    pr_hi_a  = jump_addr + 16'd1;
                    pr_pc    = {mem[pr_hi_a], mem[jump_addr]};
                    if (i == 0) exp_q0.push_back(pr_pc);
                    else        exp_q1.push_back(pr_pc);
                end
            end else if (m_cnt[i] == lat_of(i) + 3) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
    end

    // Monitor: memory with latency, PC load unit, per-cycle output checks, scoreboard compare
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mon_lat  = lat_of(i);
            mon_k    = m_cnt[i];
            mon_slot = cyc % 8;
            if (reset) begin
                for (int s = 0; s < 8; s++) rd_vld[i][s] = 1'b0;
                lo_seen[i] = 1'b0;
                rd_idx[i]  = (i == 0) ? exp_q0.size() : exp_q1.size();
            end else begin
                mon_rdata = rd_vld[i][mon_slot] ? rd_dat[i][mon_slot] : 8'hxx;
                rd_vld[i][mon_slot] = 1'b0;
                if (mem_rd_w[i] === 1'b1) begin
                    rd_vld[i][(cyc + mon_lat) % 8] = 1'b1;
                    rd_dat[i][(cyc + mon_lat) % 8] = mem[mem_addr_w[i]];
                end

                mon_idle  = (mon_k == 0);
                mon_grant = mon_idle && fetch_req && !jump_req;
                chk("busy", i, 32'(busy_w[i]), 32'(!mon_idle));
                chk("fetch_grant", i, 32'(fetch_grant_w[i]), 32'(mon_grant));
                chk("mem_rd", i, 32'(mem_rd_w[i]), 32'(mon_idle ? mon_grant : (mon_k == 1 || mon_k == 2)));
                mon_hi_a = m_ptr[i] + 16'd1;
                if (mon_idle)       chk("mem_addr_fetch", i, 32'(mem_addr_w[i]), 32'(fetch_addr));
                else if (mon_k == 1) chk("mem_addr_lo", i, 32'(mem_addr_w[i]), 32'(m_ptr[i]));
                else if (mon_k == 2) chk("mem_addr_hi", i, 32'(mem_addr_w[i]), 32'(mon_hi_a));
                chk("pc_load", i, 32'(pc_load_w[i]), 32'((mon_k == mon_lat + 1) || (mon_k == mon_lat + 2)));
                chk("pc_write", i, 32'(pc_write_w[i]), 32'(mon_k == mon_lat + 3));
                chk("done", i, 32'(done_w[i]), 32'(mon_k == mon_lat + 3));

                if (pc_load_w[i] === 1'b1) begin
                    if (!lo_seen[i]) begin
                        lo_b[i]    = mon_rdata;
                        lo_seen[i] = 1'b1;
                    end else begin
                        hi_b[i] = mon_rdata;
                    end
                end else begin
                    lo_seen[i] = 1'b0;
                end

                if (pc_write_w[i] === 1'b1) begin
                    mon_got  = {hi_b[i], lo_b[i]};
                    mon_have = (i == 0) ? (rd_idx[0] < exp_q0.size()) : (rd_idx[1] < exp_q1.size());
                    if (!mon_have) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL pc_write_unexpected L=%0d cyc=%0d got=%0h exp=none", mon_lat, cyc, mon_got);
                    end else begin
                        mon_exp = (i == 0) ? exp_q0[rd_idx[0]] : exp_q1[rd_idx[1]];
                        chk("pc_value", i, 32'(mon_got), 32'(mon_exp));
                        rd_idx[i] = rd_idx[i] + 1;
                    end
                    if (const_vld) chk("pc_directed", i, 32'(mon_got), 32'(const_pc));
                end
            end
        end
        if (final_chk && !final_done) begin
            chk("sb_drain", 0, 32'(rd_idx[0]), 32'(exp_q0.size()));
            chk("sb_drain", 1, 32'(rd_idx[1]), 32'(exp_q1.size()));
            final_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_jump(input logic [15:0] a, input logic [15:0] exp_pc);
        jump_req  = 1'b1;
        jump_addr = a;
        const_pc  = exp_pc;
        const_vld = 1'b1;
        step();
        jump_req  = 1'b0;
        jump_addr = 16'hDEAD;
        repeat (10) step();
        const_vld = 1'b0;
        step();
    endtask

    initial begin
        reset      = 1'b1;
        jump_req   = 1'b0;
        jump_addr  = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        const_vld  = 1'b0;
        const_pc   = '0;
        final_chk  = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();

        // Basic jump, then pointer at the top of memory wrapping to 0x0000
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;
        run_jump(16'h0100, 16'h1234);
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0000] = 8'hAB;
        run_jump(16'hFFFF, 16'hABCD);

        // Jump and fetch together: jump wins, fetch returns after COMMIT while held
        fetch_addr = 16'h0400;
        fetch_req  = 1'b1;
        jump_req   = 1'b1;
        jump_addr  = 16'h0100;
        step();
        jump_req = 1'b0;
        repeat (10) step();
        fetch_req = 1'b0;
        step();

        // jump_req held: back-to-back sequences, then a pulse while busy
        jump_req  = 1'b1;
        jump_addr = 16'h0010;
        step();
        jump_addr = 16'h0020;
        repeat (7) step();
        jump_req = 1'b0;
        step();
        jump_req = 1'b1;
        step();
        jump_req = 1'b0;
        repeat (12) step();

        // Reset during ISSUE_HI, then a fresh jump
        jump_req  = 1'b1;
        jump_addr = 16'h0200;
        step();
        jump_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();
        mem[16'h0300] = 8'h78;
        mem[16'h0301] = 8'h56;
        run_jump(16'h0300, 16'h5678);

        for (int n = 0; n < 3000; n++) begin
            jump_req   = ($urandom_range(0, 3) == 0);
            jump_addr  = 16'($urandom);
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = 16'($urandom);
            reset      = ($urandom_range(0, 249) == 0);
            step();
        end
        jump_req  = 1'b0;
        fetch_req = 1'b0;
        reset     = 1'b0;
        repeat (12) step();
        final_chk = 1'b1;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
